// File: rtl/apple_logic.sv
// apple_logic: apple/score engine for the VGA snake game.
// Define APPLE_AVOID_HEAD_EN to keep the proposed apple off the head cell.
module apple_logic #(
    parameter int unsigned CELL = 20,
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 24,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] newposx,
    input  logic [9:0] newposy,
    input  logic [9:0] applex,
    input  logic [9:0] appley,
    output logic [7:0] score,
    output logic [9:0] newapplex,
    output logic [9:0] newappley
);

    localparam logic [9:0] XRST  = 10'((COLS / 2) * CELL);
    localparam logic [9:0] YRST  = 10'((ROWS / 2) * CELL);
    localparam logic [4:0] YLIM  = 5'(ROWS);
    localparam logic [4:0] YFOLD = 5'(32 - ROWS);

    logic [15:0] lfsr;
    logic        fb;
    logic        eaten;
    logic        eaten_q;
    logic        eat;
    logic [4:0]  cx;
    logic [4:0]  ry;
    logic [4:0]  cy;
    logic [9:0]  candx;
    logic [9:0]  candy;
    logic [9:0]  nextx;

    // cell index to pixels: c*20 as c*16 + c*4
    function automatic logic [9:0] cell_px(input logic [4:0] c);
        logic [9:0] w;
        w = {5'd0, c};
        return (w << 4) + (w << 2);
    endfunction

    always_comb begin
        fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        eaten = (newposx == applex) && (newposy == appley);
        eat   = eaten && !eaten_q;
        cx    = lfsr[4:0];
        ry    = lfsr[12:8];
        cy    = (ry >= YLIM) ? ry - YFOLD : ry;
        candx = cell_px(cx);
        candy = cell_px(cy);
`ifdef APPLE_AVOID_HEAD_EN
        if (candx == newposx && candy == newposy)
            nextx = cell_px(cx + 5'd1);
        else
            nextx = candx;
`else
        nextx = candx;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score     <= 8'd0;
            newapplex <= XRST;
            newappley <= YRST;
            lfsr      <= SEED;
            eaten_q   <= 1'b0;
        end else begin
            lfsr    <= {lfsr[14:0], fb};
            eaten_q <= eaten;
            if (eat) begin
                score     <= score + 8'd1;
                newapplex <= nextx;
                newappley <= candy;
            end
        end
    end

endmodule

// File: tb/tb_apple_logic.sv
// tb_apple_logic: randomized bench for apple_logic against a
// behavioural model of the scoring and apple placement rules.
module tb_apple_logic;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] newposx = 10'd0;
    logic [9:0] newposy = 10'd0;
    logic [9:0] applex = 10'd0;
    logic [9:0] appley = 10'd0;
    logic [7:0] score;
    logic [9:0] newapplex;
    logic [9:0] newappley;

    int n_chk = 0;
    int n_pass = 0;

    int unsigned m_score;
    int unsigned m_x;
    int unsigned m_y;
    int unsigned m_lfsr;
    bit          m_on;
    bit          m_ate;
    int unsigned n_eats;

    apple_logic dut (
        .clk(clk),
        .rst_n(rst_n),
        .newposx(newposx),
        .newposy(newposy),
        .applex(applex),
        .appley(appley),
        .score(score),
        .newapplex(newapplex),
        .newappley(newappley)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // x^16 + x^14 + x^13 + x^11 + 1, new bit enters at the bottom
    function automatic int unsigned lfsr_next(input int unsigned s);
        int unsigned b;
        b = ((s >> 15) + (s >> 13) + (s >> 12) + (s >> 10)) % 2;
        return ((s * 2) % 65536) + b;
    endfunction

    task automatic model_edge();
        bit          on;
        int unsigned cx;
        int unsigned cy;
        m_ate = 0;
        if (!rst_n) begin
            m_score = 0;
            m_x = 320;
            m_y = 240;
            m_lfsr = 16'hACE1;
            m_on = 0;
            return;
        end
        on = (newposx == applex) && (newposy == appley);
        if (on && !m_on) begin
            m_ate = 1;
            n_eats++;
            m_score = (m_score + 1) % 256;
            cx = m_lfsr % 32;
            cy = (m_lfsr / 256) % 32;
            if (cy >= 24) cy = cy - 8;
`ifdef APPLE_AVOID_HEAD_EN
            if (cx * 20 == newposx && cy * 20 == newposy)
                cx = (cx + 1) % 32;
`endif
            m_x = cx * 20;
            m_y = cy * 20;
        end
        m_on = on;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic step();
        logic [9:0] hx;
        logic [9:0] hy;
        hx = newposx;
        hy = newposy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("score", score, m_score);
        chk("newapplex", newapplex, m_x);
        chk("newappley", newappley, m_y);
        chk("x_range", (newapplex <= 620) && (newapplex % 20 == 0), 1);
        chk("y_range", (newappley <= 460) && (newappley % 20 == 0), 1);
`ifdef APPLE_AVOID_HEAD_EN
        if (m_ate)
            chk("avoid_head", (newapplex != hx) || (newappley != hy), 1);
`endif
    endtask

    task automatic head_off();
        newposx = (applex == 10'd0) ? 10'd20 : 10'd0;
        newposy = appley;
    endtask

    initial begin
        n_eats = 0;
        // reset
        rst_n = 1'b0;
        step();
        step();
        chk("rst_score", score, 0);
        chk("rst_x", newapplex, 320);
        chk("rst_y", newappley, 240);

        // idle: head away from apple
        rst_n = 1'b1;
        newposx = 10'd20;
        newposy = 10'd0;
        applex = 10'd320;
        appley = 10'd240;
        for (int i = 0; i < 100; i++) step();
        chk("idle_score", score, 0);

        // first eat, then hold head on the apple
        newposx = 10'd320;
        newposy = 10'd240;
        step();
        chk("first_eat", score, 1);
        for (int i = 0; i < 1000; i++) step();
        chk("hold_score", score, 1);

        // leave, parent latches new apple, return onto it
        head_off();
        step();
        applex = 10'(m_x);
        appley = 10'(m_y);
        head_off();
        step();
        newposx = applex;
        newposy = appley;
        step();
        chk("second_eat", score, 2);
        chk("bit0_toggle", score[0], 0);

        // forced eats across the 255->0 wrap
        for (int i = 0; i < 260; i++) begin
            head_off();
            step();
            newposx = applex;
            newposy = appley;
            step();
        end
        chk("wrap_score", score, (2 + 260) % 256);

        // reset during an eat cycle
        head_off();
        step();
        newposx = applex;
        newposy = appley;
        rst_n = 1'b0;
        step();
        chk("rst_eat_score", score, 0);
        chk("rst_eat_x", newapplex, 320);
        rst_n = 1'b1;

        // random play
        for (int i = 0; i < 12000; i++) begin
            case ($urandom_range(0, 4))
                0, 1: begin
                    newposx = applex;
                    newposy = appley;
                end
                2: begin
                    applex = 10'(m_x);
                    appley = 10'(m_y);
                end
                3: begin
                    newposx = 10'(20 * $urandom_range(0, 31));
                    newposy = 10'(20 * $urandom_range(0, 23));
                end
                default: begin
                    newposx = 10'(m_x);
                    newposy = 10'(m_y);
                end
            endcase
            step();
        end
        chk("rand_eats_seen", n_eats > 1000, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
